// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the RV32I pipeline: widths, reset vector, bubble
// encoding and the instruction-fetch state encoding.
package cpu_defs;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] BUBBLE           = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_byte_asm.sv
// Four-byte little-endian capture register. The word output forwards a byte
// being written this cycle so the fetch stage can latch a complete instruction
// on the same edge that the last byte arrives.
module if_byte_asm
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        i_clr,
    input  logic        i_we,
    input  logic [1:0]  i_idx,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word
);

    logic [7:0] r_bytes [4];
    logic [7:0] w_bytes [4];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < 4; i++) begin
                r_bytes[i] <= 8'h00;
            end
        end else if (i_we) begin
            r_bytes[i_idx] <= i_byte;
        end
    end

    // Write-through of the incoming byte.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_bytes[i] = (i_we && (i_idx == 2'(i))) ? i_byte : r_bytes[i];
        end
    end

    assign o_word = {w_bytes[3], w_bytes[2], w_bytes[1], w_bytes[0]};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, reads each instruction as four bytes
// over the shared byte-wide memory port and presents it to decode.
module if_fetch
    import cpu_defs::*;
#(
    parameter int              XLEN     = cpu_defs::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_defs::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_grant,
    output logic            mem_rd,
    output logic [XLEN-1:0] mem_a,
    input  logic [7:0]      mem_din,
    input  logic            stall_i,
    input  logic            jmp_e,
    input  logic [XLEN-1:0] jmp_pc,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     is_o,
    output logic [XLEN-1:0] ppc_o
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_k;
    logic            r_pend;
    logic [1:0]      r_pend_idx;
    logic            r_valid;
    logic [XLEN-1:0] r_pc_o;
    logic [31:0]     r_is;
    logic [XLEN-1:0] r_ppc;

    logic            w_issue;
    logic            w_done;
    logic            w_consume;
    logic            w_asm_we;
    logic            w_asm_clr;
    logic [31:0]     w_word;

    // A redirect or reset discards any byte still in flight.
    assign w_asm_clr = rst | jmp_e;
    assign w_asm_we  = r_pend & ~w_asm_clr;

    if_byte_asm u_byte_asm (
        .clk    (clk),
        .i_clr  (w_asm_clr),
        .i_we   (w_asm_we),
        .i_idx  (r_pend_idx),
        .i_byte (mem_din),
        .o_word (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if ((r_k < 3'd4) && mem_grant) begin
                    w_issue = 1'b1;
                    if (r_k == 3'd3) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_pend && (r_pend_idx == 2'd3)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    w_consume   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
        if (jmp_e) begin
            w_state_nxt = ST_FETCH;
        end
        if (rst) begin
            w_state_nxt = ST_FETCH;
            w_issue     = 1'b0;
        end
    end

    assign mem_rd = w_issue;
    assign mem_a  = w_issue ? (r_pc + XLEN'(r_k)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_k        <= 3'd0;
            r_pend     <= 1'b0;
            r_pend_idx <= 2'd0;
            r_valid    <= 1'b0;
            r_pc_o     <= '0;
            r_is       <= BUBBLE;
            r_ppc      <= '0;
        end else if (jmp_e) begin
            r_pc    <= jmp_pc;
            r_k     <= 3'd0;
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
            r_is    <= BUBBLE;
        end else begin
            r_pend <= w_issue;
            if (w_issue) begin
                r_k        <= r_k + 3'd1;
                r_pend_idx <= r_k[1:0];
            end
            if (w_done) begin
                r_is    <= w_word;
                r_pc_o  <= r_pc;
                r_ppc   <= r_pc + XLEN'(4);
                r_valid <= 1'b1;
            end
            if (w_consume) begin
                r_pc    <= r_pc + XLEN'(4);
                r_k     <= 3'd0;
                r_valid <= 1'b0;
                r_is    <= BUBBLE;
            end
        end
    end

    assign valid_o = r_valid;
    assign pc_o    = r_pc_o;
    assign is_o    = r_is;
    assign ppc_o   = r_ppc;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed scenarios push expected byte
// addresses and instructions; a negedge monitor pops and compares them.
module tb_if_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] is;
        logic [31:0] ppc;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_grant = 1'b0;
    logic        mem_rd;
    logic [31:0] mem_a;
    logic [7:0]  mem_din = 8'h00;
    logic        stall_i = 1'b0;
    logic        jmp_e = 1'b0;
    logic [31:0] jmp_pc = 32'h0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] is_o;
    logic [31:0] ppc_o;

    int          errors = 0;
    int          checks = 0;
    logic        prevValid = 1'b0;
    logic [31:0] addrQ [$];
    instr_t      instrQ [$];

    if_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .mem_grant (mem_grant),
        .mem_rd    (mem_rd),
        .mem_a     (mem_a),
        .mem_din   (mem_din),
        .stall_i   (stall_i),
        .jmp_e     (jmp_e),
        .jmp_pc    (jmp_pc),
        .valid_o   (valid_o),
        .pc_o      (pc_o),
        .is_o      (is_o),
        .ppc_o     (ppc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memByte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h13;
            32'h1:   return 8'h05;
            32'h2:   return 8'h10;
            32'h3:   return 8'h00;
            32'h4:   return 8'h93;
            32'h5:   return 8'h00;
            32'h6:   return 8'h20;
            32'h7:   return 8'h00;
            32'h100: return 8'h6F;
            32'h101: return 8'h00;
            32'h102: return 8'h00;
            32'h103: return 8'h00;
            32'h104: return 8'hB3;
            32'h105: return 8'h00;
            32'h106: return 8'h21;
            32'h107: return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Byte memory with one cycle of read latency; non-read cycles return junk.
    always @(posedge clk) begin
        mem_din <= mem_rd ? memByte(mem_a) : 8'hA5;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic g, input logic s,
                                 input logic j, input logic [31:0] jp);
        rst       = r;
        mem_grant = g;
        stall_i   = s;
        jmp_e     = j;
        jmp_pc    = jp;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushAddrs(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            addrQ.push_back(base + 32'(i));
        end
    endtask

    task automatic pushInstr(input logic [31:0] pc, input logic [31:0] is,
                             input logic [31:0] ppc);
        instr_t e;
        e.pc  = pc;
        e.is  = is;
        e.ppc = ppc;
        instrQ.push_back(e);
    endtask

    // Leaves the bench at the start of the cycle after the last reset edge, rst still 1.
    task automatic applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rst_valid", {31'h0, valid_o}, 32'h0);
        checkOutput("rst_is", is_o, 32'h0);
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_ppc", ppc_o, 32'h0);
        checkOutput("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        checkOutput("rst_mem_a", mem_a, 32'h0);
        nextCycle();
    endtask

    // Monitor: every issued address and every newly presented instruction is scored.
    always @(negedge clk) begin
        instr_t e;
        if (mem_rd) begin
            if (addrQ.size() == 0) begin
                errors++;
                checks++;
                $display("[TB] FAIL unexpected_issue: got mem_a=%h, expected no read", mem_a);
            end else begin
                checkOutput("mem_a_seq", mem_a, addrQ.pop_front());
            end
        end
        if (!valid_o) begin
            checkOutput("bubble_is", is_o, 32'h0);
        end else if (!prevValid && !rst) begin
            if (instrQ.size() == 0) begin
                errors++;
                checks++;
                $display("[TB] FAIL unexpected_instr: got pc_o=%h, expected none", pc_o);
            end else begin
                e = instrQ.pop_front();
                checkOutput("instr_pc", pc_o, e.pc);
                checkOutput("instr_is", is_o, e.is);
                checkOutput("instr_ppc", ppc_o, e.ppc);
            end
        end
        prevValid = valid_o;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Basic fetch, latency, stall hold and release.
        applyReset();
        pushAddrs(32'h0, 8);
        pushAddrs(32'h8, 1);
        pushInstr(32'h0, 32'h0010_0513, 32'h4);
        pushInstr(32'h4, 32'h0020_0093, 32'h8);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t0_mem_rd", {31'h0, mem_rd}, 32'h1);
        checkOutput("t0_mem_a", mem_a, 32'h0);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("t5_valid", {31'h0, valid_o}, 32'h1);
        nextCycle();
        stall_i = 1'b1;
        @(negedge clk);
        checkOutput("t6_mem_a", mem_a, 32'h4);
        repeat (5) nextCycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'h0, valid_o}, 32'h1);
            checkOutput("stall_pc", pc_o, 32'h4);
            checkOutput("stall_is", is_o, 32'h0020_0093);
            checkOutput("stall_mem_rd", {31'h0, mem_rd}, 32'h0);
            nextCycle();
        end
        stall_i = 1'b0;
        @(negedge clk);
        checkOutput("release_valid", {31'h0, valid_o}, 32'h1);
        nextCycle();
        @(negedge clk);
        checkOutput("consumed_valid", {31'h0, valid_o}, 32'h0);
        checkOutput("consumed_mem_a", mem_a, 32'h8);

        // Grant withheld for two cycles after the first byte.
        nextCycle();
        applyReset();
        pushAddrs(32'h0, 4);
        pushInstr(32'h0, 32'h0010_0513, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        mem_grant = 1'b0;
        @(negedge clk);
        checkOutput("nogrant_mem_rd", {31'h0, mem_rd}, 32'h0);
        nextCycle();
        nextCycle();
        mem_grant = 1'b1;
        @(negedge clk);
        checkOutput("regrant_mem_a", mem_a, 32'h1);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("gap_t6_valid", {31'h0, valid_o}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("gap_t7_valid", {31'h0, valid_o}, 32'h1);

        // Redirect after two bytes, then redirect from a stalled HOLD.
        nextCycle();
        applyReset();
        pushAddrs(32'h0, 2);
        pushAddrs(32'h100, 4);
        pushInstr(32'h100, 32'h0000_006F, 32'h104);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("jmp_first_a", mem_a, 32'h100);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("jmp_valid", {31'h0, valid_o}, 32'h1);
        checkOutput("jmp_pc_o", pc_o, 32'h100);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h104);
        pushAddrs(32'h104, 4);
        pushInstr(32'h104, 32'h0021_00B3, 32'h108);
        @(negedge clk);
        checkOutput("holdjmp_pre_valid", {31'h0, valid_o}, 32'h1);
        nextCycle();
        jmp_e = 1'b0;
        @(negedge clk);
        checkOutput("holdjmp_valid", {31'h0, valid_o}, 32'h0);
        checkOutput("holdjmp_is", is_o, 32'h0);
        checkOutput("holdjmp_mem_a", mem_a, 32'h104);
        repeat (5) nextCycle();
        stall_i = 1'b0;
        @(negedge clk);
        checkOutput("holdjmp_valid2", {31'h0, valid_o}, 32'h1);

        // Reset while draining the last byte of 0x108.
        pushAddrs(32'h108, 4);
        repeat (5) nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("drain_mem_rd", {31'h0, mem_rd}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        pushAddrs(32'h0, 4);
        pushInstr(32'h0, 32'h0010_0513, 32'h4);
        @(negedge clk);
        checkOutput("postrst_valid", {31'h0, valid_o}, 32'h0);
        checkOutput("postrst_mem_a", mem_a, 32'h0);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("postrst_valid2", {31'h0, valid_o}, 32'h1);

        // PC wrap at the top of memory, then a misaligned redirect.
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        pushAddrs(32'hFFFF_FFFC, 4);
        pushAddrs(32'h0, 2);
        pushAddrs(32'h102, 4);
        pushInstr(32'hFFFF_FFFC, 32'hA5A4_A7A6, 32'h0);
        pushInstr(32'h102, 32'h00B3_0000, 32'h106);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("wrap_ppc", ppc_o, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("wrap_next_a", mem_a, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h102);
        @(negedge clk);
        checkOutput("jmpcycle_mem_a", mem_a, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("misalign_valid", {31'h0, valid_o}, 32'h1);
        nextCycle();
        mem_grant = 1'b0;
        repeat (3) nextCycle();

        checkOutput("addrq_empty", 32'(addrQ.size()), 32'h0);
        checkOutput("instrq_empty", 32'(instrQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. It is the producer end of the IF→ID interface: it owns the PC, reads each 32-bit instruction as four bytes over the shared byte-wide memory port, and presents pc/is/ppc to the decode stage. It honours a stall from ID/hazard logic and a redirect (npc) from the branch/jump resolution path. When nothing valid is held, it drives is_o = 0, which the decode stage treats as a bubble.

Parameters:
RESET_PC, 32'h0, PC loaded on reset
XLEN, 32, address/instruction width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_grant  in  1  1 = IF owns the memory port this cycle (MEM stage has priority)
mem_rd  out  1  byte read strobe, valid this cycle
mem_a  out  32  byte address, qualified by mem_rd
mem_din  in  8  read data for the address issued in the previous cycle
stall_i  in  1  downstream not ready; hold the presented instruction
jmp_e  in  1  redirect request
jmp_pc  in  32  redirect target
valid_o  out  1  pc_o/is_o/ppc_o carry a real instruction
pc_o  out  32  address of the presented instruction
is_o  out  32  instruction word, 32'h0 when valid_o = 0
ppc_o  out  32  predicted next PC, always pc_o + 4

Behaviour:
- Reset (rst = 1 at a clock edge): pc <= RESET_PC; state <= FETCH; issue count k <= 0; pend <= 0; valid_o = 0; is_o = 0; pc_o = 0; ppc_o = 0. Combinational outputs mem_rd = 0 and mem_a = 0 while rst = 1. Reset mid-fetch discards all partial bytes.
- States: FETCH, DRAIN, HOLD.
  - FETCH: issues addresses pc+k for k = 0..3.
  - DRAIN: waits for the last byte.
  - HOLD: presents the instruction.
- Issue (combinational): in FETCH with k < 4 and mem_grant = 1, drive mem_rd = 1 and mem_a = pc + k. At the clock edge, k <= k + 1 and pend <= 1 with pend_idx <= k. Otherwise mem_rd = 0 and pend <= 0.
- Capture: when pend = 1, byte[pend_idx] <= mem_din. A capture happens even if mem_grant = 0 in that cycle, because the data belongs to the previous issue.
- Grant low: issue pauses and k is frozen. No byte is issued twice or lost.
- Assembly is little-endian: is = {b3, b2, b1, b0}.
- FETCH → DRAIN after byte 3 is issued. DRAIN → HOLD at the edge where byte 3 is captured. At that edge: is_o <= assembled word, pc_o <= pc, ppc_o <= pc + 4, valid_o <= 1.
- Latency: with grant held at 1, bytes are issued in T0..T3 and captured in T1..T4, and valid_o = 1 from T5.
- HOLD: outputs are held stable while stall_i = 1. When stall_i = 0 at an edge, the instruction counts as consumed: pc <= pc + 4, k <= 0, valid_o <= 0, is_o <= 0, state <= FETCH. There is no prefetch, so throughput is one instruction per 6 cycles with full grant.
- Redirect: jmp_e = 1 at an edge, in any state, sets pc <= jmp_pc, k <= 0, pend <= 0, valid_o <= 0, is_o <= 0, state <= FETCH. A byte in flight is discarded. mem_rd is still driven normally in the jmp_e cycle, and its return is ignored.
- Priority: rst > jmp_e > normal operation. jmp_e together with stall_i in HOLD still redirects.
- PC arithmetic is mod 2^32. pc = 32'hFFFF_FFFC wraps to 0. No alignment check: misaligned jmp_pc is fetched as given.

Decomposition:
- Shared package (cpu_defs): XLEN, RESET_PC default, BUBBLE = 32'h0, fetch state encoding.
- One natural sub-module, if_byte_asm: a 4×8 capture register with byte-index write enable and clear, producing the 32-bit word.

Test Plan:
- Reset, memory[0..3] = 13 05 10 00, grant = 1, stall = 0 → mem_a = 0,1,2,3 in T0..T3; valid_o = 1 in T5 with is_o = 32'h00100513, pc_o = 0, ppc_o = 4; next mem_a = 4 in T6.
- mem_grant = 0 during T1–T2 of the fetch above → mem_a sequence 0 (stall) 1,2,3 with no duplicates; is_o still 32'h00100513, valid_o 2 cycles later.
- Hold stall_i = 1 for 3 cycles after valid → pc_o/is_o stable, mem_rd = 0; release stall → valid_o drops next cycle and fetch starts at 4.
- jmp_e = 1, jmp_pc = 32'h100 after 2 bytes issued → partial bytes dropped, next mem_a = 32'h100; presented pc_o = 32'h100.
- jmp_e during HOLD with stall_i = 1 → valid_o = 0, is_o = 0 next cycle; fetch restarts at jmp_pc.
- rst asserted mid-DRAIN → next cycle valid_o = 0, mem_a = RESET_PC, and no stale byte appears in the first instruction.
